// File: rtl/muldiv_sequencer_if.sv
// rtl/muldiv_sequencer_if.sv - handshake bundle between control unit, sequencer and mult/div/HI/LO slice
// Ports (master = control unit/datapath side, slave = sequencer):
//   start, op, divisor, abort    : request from control unit
//   mult_done, div_done          : completion pulses from the iterative units
//   mult_start, div_start        : one-cycle launch pulses to the units
//   HI_mux_control, LO_mux_control, HI_control, LO_control : HI/LO select and write enables
//   busy, done, division_by_zero, timeout : status back to control unit
interface muldiv_sequencer_if;
  logic        start;
  logic        op;
  logic [31:0] divisor;
  logic        abort;
  logic        mult_done;
  logic        div_done;
  logic        mult_start;
  logic        div_start;
  logic        HI_mux_control;
  logic        LO_mux_control;
  logic        HI_control;
  logic        LO_control;
  logic        busy;
  logic        done;
  logic        division_by_zero;
  logic        timeout;

  modport master (
    output start, op, divisor, abort, mult_done, div_done,
    input  mult_start, div_start, HI_mux_control, LO_mux_control,
           HI_control, LO_control, busy, done, division_by_zero, timeout
  );

  modport slave (
    input  start, op, divisor, abort, mult_done, div_done,
    output mult_start, div_start, HI_mux_control, LO_mux_control,
           HI_control, LO_control, busy, done, division_by_zero, timeout
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - Moore FSM sequencing MULT/DIV units and HI/LO commit
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous active-high; forces IDLE and all outputs low
//   bus   : muldiv_sequencer_if.slave (request in, unit launch/done, HI/LO controls, status out)
module muldiv_sequencer #(
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  muldiv_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_WRITE,
    ST_DONE,
    ST_DZERO,
    ST_ERR
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state_q;
  state_t           state_d;
  logic             op_q;
  logic [CNT_W-1:0] wait_cnt;
  logic             unit_done;

  // Only the done of the launched unit counts; the other one is noise.
  assign unit_done = op_q ? bus.div_done : bus.mult_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= 1'b0;
      wait_cnt <= '0;
    end else begin
      state_q <= state_d;
      // op is latched for every accepted start, including div-by-zero,
      // so the mux selects read as DIV during DZERO.
      if (state_q == ST_IDLE && bus.start) begin
        op_q <= bus.op;
      end
      if (state_q == ST_LAUNCH) begin
        wait_cnt <= '0;
      end else if (state_q == ST_WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = (bus.op && (bus.divisor == 32'd0)) ? ST_DZERO : ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (unit_done) begin
          state_d = ST_WRITE;
        end else if (wait_cnt == CNT_LAST) begin
          state_d = ST_ERR;
        end
      end
      ST_WRITE: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      ST_DZERO: state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // abort overrides every transition, but never blocks a start from IDLE.
    if (bus.abort && state_q != ST_IDLE) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    bus.mult_start       = 1'b0;
    bus.div_start        = 1'b0;
    bus.HI_control       = 1'b0;
    bus.LO_control       = 1'b0;
    bus.done             = 1'b0;
    bus.division_by_zero = 1'b0;
    bus.timeout          = 1'b0;
    bus.busy             = (state_q != ST_IDLE);
    bus.HI_mux_control   = bus.busy & ~op_q;
    bus.LO_mux_control   = bus.busy & ~op_q;
    case (state_q)
      ST_LAUNCH: begin
        bus.mult_start = ~op_q;
        bus.div_start  = op_q;
      end
      ST_WRITE: begin
        bus.HI_control = 1'b1;
        bus.LO_control = 1'b1;
      end
      ST_DONE:  bus.done = 1'b1;
      ST_DZERO: begin
        bus.division_by_zero = 1'b1;
        bus.done             = 1'b1;
      end
      ST_ERR:   bus.timeout = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - directed self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  muldiv_sequencer_if bus ();

  muldiv_sequencer #(.TIMEOUT(40), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector order:
  // {mult_start, div_start, HI_mux, LO_mux, HI_ctl, LO_ctl, busy, done, dzero, timeout}
  localparam logic [9:0] O_IDLE     = 10'b0000000000;
  localparam logic [9:0] O_M_LAUNCH = 10'b1011001000;
  localparam logic [9:0] O_M_WAIT   = 10'b0011001000;
  localparam logic [9:0] O_M_WRITE  = 10'b0011111000;
  localparam logic [9:0] O_M_DONE   = 10'b0011001100;
  localparam logic [9:0] O_M_ERR    = 10'b0011001001;
  localparam logic [9:0] O_D_LAUNCH = 10'b0100001000;
  localparam logic [9:0] O_D_WAIT   = 10'b0000001000;
  localparam logic [9:0] O_D_WRITE  = 10'b0000111000;
  localparam logic [9:0] O_D_DONE   = 10'b0000001100;
  localparam logic [9:0] O_DZERO    = 10'b0000001110;

  function automatic logic [9:0] outs();
    return {bus.mult_start, bus.div_start, bus.HI_mux_control, bus.LO_mux_control,
            bus.HI_control, bus.LO_control, bus.busy, bus.done,
            bus.division_by_zero, bus.timeout};
  endfunction

  task automatic check(input string tag, input logic [9:0] expected);
    logic [9:0] observed;
    observed = outs();
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
    end
  endtask

  // Advance through one rising edge and land on the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    reset         = 1'b1;
    bus.start     = 1'b0;
    bus.op        = 1'b0;
    bus.divisor   = 32'd0;
    bus.abort     = 1'b0;
    bus.mult_done = 1'b0;
    bus.div_done  = 1'b0;

    @(negedge clk);
    @(negedge clk);
    check("reset_state", O_IDLE);
    reset = 1'b0;
    tick();
    check("idle_after_reset", O_IDLE);

    // MULT, mult_done on the 3rd WAIT cycle
    bus.start = 1'b1; bus.op = 1'b0; bus.divisor = 32'd5;
    tick();
    bus.start = 1'b0;
    check("mult_launch_c1", O_M_LAUNCH);
    tick(); check("mult_wait_c2", O_M_WAIT);
    tick(); check("mult_wait_c3", O_M_WAIT);
    tick(); check("mult_wait_c4", O_M_WAIT);
    bus.mult_done = 1'b1;
    tick();
    bus.mult_done = 1'b0;
    check("mult_write_c5", O_M_WRITE);
    tick(); check("mult_done_c6", O_M_DONE);
    tick(); check("mult_idle_c7", O_IDLE);

    // DIV by zero
    bus.start = 1'b1; bus.op = 1'b1; bus.divisor = 32'd0;
    tick();
    bus.start = 1'b0;
    check("dzero_pulse", O_DZERO);
    tick(); check("dzero_idle", O_IDLE);
    tick(); check("dzero_idle_hold", O_IDLE);

    // DIV normal, div_done after 33 WAIT cycles, stray mult_done ignored
    bus.start = 1'b1; bus.op = 1'b1; bus.divisor = 32'd7;
    tick();
    bus.start = 1'b0;
    check("div_launch", O_D_LAUNCH);
    for (int i = 1; i <= 33; i++) begin
      tick();
      bus.mult_done = (i == 10);
      bus.div_done  = (i == 33);
      check($sformatf("div_wait_%0d", i), O_D_WAIT);
    end
    tick();
    bus.div_done  = 1'b0;
    bus.mult_done = 1'b0;
    check("div_write", O_D_WRITE);
    tick(); check("div_done", O_D_DONE);
    tick(); check("div_idle", O_IDLE);

    // Timeout: 40 WAIT cycles, then ERR for one cycle
    bus.start = 1'b1; bus.op = 1'b0; bus.divisor = 32'd3;
    tick();
    bus.start = 1'b0;
    check("to_launch", O_M_LAUNCH);
    for (int i = 1; i <= 40; i++) begin
      tick();
      check($sformatf("to_wait_%0d", i), O_M_WAIT);
    end
    tick(); check("to_err", O_M_ERR);
    tick(); check("to_idle", O_IDLE);

    // Abort in WAIT with mult_done high; start during WAIT ignored
    bus.start = 1'b1; bus.op = 1'b0;
    tick();
    bus.start = 1'b0;
    check("ab_launch", O_M_LAUNCH);
    tick(); check("ab_wait1", O_M_WAIT);
    bus.start = 1'b1; bus.op = 1'b1; bus.divisor = 32'd0;
    tick();
    bus.start = 1'b0; bus.op = 1'b0; bus.divisor = 32'd9;
    check("ab_busy_start_ignored", O_M_WAIT);
    bus.abort = 1'b1; bus.mult_done = 1'b1;
    tick();
    bus.abort = 1'b0; bus.mult_done = 1'b0;
    check("ab_to_idle", O_IDLE);
    tick(); check("ab_no_write", O_IDLE);

    // abort in IDLE does not block a simultaneous start
    bus.start = 1'b1; bus.abort = 1'b1; bus.op = 1'b0;
    tick();
    bus.start = 1'b0; bus.abort = 1'b0;
    check("idle_abort_start", O_M_LAUNCH);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check("launch_abort", O_IDLE);

    // Async reset mid-WRITE, then a fresh MULT
    bus.start = 1'b1; bus.op = 1'b0;
    tick();
    bus.start = 1'b0;
    tick();
    bus.mult_done = 1'b1;
    tick();
    bus.mult_done = 1'b0;
    check("rst_pre_write", O_M_WRITE);
    #2 reset = 1'b1;
    #1 check("rst_async_clear", O_IDLE);
    @(negedge clk);
    check("rst_held", O_IDLE);
    reset = 1'b0;
    bus.start = 1'b1; bus.op = 1'b0;
    tick();
    bus.start = 1'b0;
    check("post_rst_launch", O_M_LAUNCH);
    tick();
    bus.mult_done = 1'b1;
    check("post_rst_wait", O_M_WAIT);
    tick();
    bus.mult_done = 1'b0;
    check("post_rst_write", O_M_WRITE);
    tick(); check("post_rst_done", O_M_DONE);
    tick(); check("post_rst_idle", O_IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
